prn_context_seq: RTL
====================

Name: prn_context_seq

Overview:
- Per-channel sequencer for the PRN code generator (general/Weil/memory-code) in the time-multiplexed correlator.
- For one channel slot it:
  - reads the channel's PRN context (configs, states, phase, epoch/flags) from the channel state RAM;
  - loads the context into the generator in the required order: phase before PRN2 state;
  - issues a commanded number of code shifts, gated by generator readiness;
  - counts code epochs and writes the updated context back.
- One instance per correlator engine, between the state-buffer RAM and the PRN generator.

Parameters:
- ADDR_WIDTH, 10, channel state RAM DWORD address width.
- SHIFT_WIDTH, 16, width of the shift-count command.

Ports:
- clk  in  1  system clock
- rst_b  in  1  asynchronous active-low reset
- start  in  1  single-cycle command; sampled only in IDLE
- abort  in  1  return to IDLE next cycle, no writeback
- ctx_base  in  ADDR_WIDTH  channel context base address, captured at start
- shift_num  in  SHIFT_WIDTH  code shifts to issue, captured at start
- busy  out  1  high from the cycle after start until DONE exits
- done  out  1  one-cycle pulse after the last writeback
- ram_rd  out  1  RAM read strobe; rdata valid next cycle
- ram_wr  out  1  RAM write strobe
- ram_addr  out  ADDR_WIDTH  RAM address
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM read data
- prn_config  out  32  registered PRN config
- prn2_config  out  32  registered PRN2 config
- prn_state_en / prn_count_en / prn2_state_en  out  1 each  load strobes
- prn_state_i / prn_count_i / prn2_state_i  out  32 each  load data, equal to ram_rdata
- prn_state_o / prn_count_o / prn2_state_o  in  32 each  generator context readback
- enable_2nd_prn  out  1  from context DWORD5[31]
- shift_code  out  1  shift strobe
- prn_reset  in  1  generator code roll-over indication
- code_ready  in  1  generator ready to shift; tie high if unused

Behaviour:
- Context layout, offset from ctx_base:
  - 0 = prn_config
  - 1 = prn2_config
  - 2 = prn_state
  - 3 = prn_count
  - 4 = prn2_state
  - 5 = {enable_2nd[31], rsvd[30:16], epoch_cnt[15:0]}
  - 6 = stall count (feature only)
- Reset values:
  - all outputs 0;
  - state IDLE;
  - internal counters 0.
- FSM states: IDLE, READ, SETTLE, SHIFT, SAVE, DONE.
- IDLE → READ on start (T0). Start while busy is ignored.
- READ (6 cycles, T1..T6):
  - ram_rd=1 with ram_addr=base+0..5; the pipelined valid tag marks each return.
  - T2: prn_config captured. T3: prn2_config captured.
  - T4: prn_state_en. T5: prn_count_en. T6: prn2_state_en.
  - T7: DWORD5 captured into enable_2nd_prn and epoch_cnt.
- SETTLE (T7, T8): two idle cycles covering the generator's delayed PRN2 phase load and its first ROM fetch. Go to SHIFT at T9.
- SHIFT:
  - shift_code = code_ready & (remaining≠0); remaining decrements on each shift.
  - epoch_cnt += 1 (16-bit wrap) when shift_code & prn_reset.
  - Exit to SAVE on the cycle remaining==0. shift_num=0 passes straight through SHIFT in one cycle.
- SAVE:
  - ram_wr on consecutive cycles to offsets 2, 3, 4, 5 (plus 6 if the feature is enabled).
  - Write data comes from the generator readbacks and {enable_2nd,15'h0,epoch_cnt}.
  - No shifts occur, so the readbacks are stable.
- DONE: done=1 for one cycle → IDLE. busy falls on the same edge.
- abort (any non-IDLE state):
  - next state IDLE, all strobes deasserted next cycle, no done pulse.
  - configs keep their last value.
  - An abort during SAVE leaves a partial writeback, which is the caller's responsibility.
- Read and write are never asserted in the same cycle.

Optional Feature:
- Macro PRN_SEQ_STALL_CNT_EN.
- Defined:
  - a 16-bit saturating counter increments each SHIFT cycle with remaining≠0 and code_ready=0;
  - it clears at start;
  - it is written to offset 6 as a fifth SAVE write, so SAVE takes 5 cycles.
- Undefined: no counter; SAVE is 4 writes; offset 6 is untouched.

Decomposition:
- Shared package prn_seq_pkg:
  - FSM state enum;
  - context offset constants CTX_CFG1=0 … CTX_STALL=6;
  - CTX_READ_LEN=6, SETTLE_CYCLES=2.
- Sub-module prn_seq_ram_if: read-tag pipeline and address generation for READ/SAVE.
- FSM, shift counter and epoch counter stay in the top.

Test Plan:
- Base 0x040, DWORD5=0x8000_0003, shift_num=5, code_ready=1:
  - load strobes at T4/T5/T6; five shift_code pulses T9..T13;
  - writes to 0x042..0x045; done at T18; enable_2nd_prn=1.
- prn_reset asserted on the 3rd shift, epoch_cnt in = 0xFFFF → written DWORD5[15:0]=0x0000 (wrap).
- code_ready toggled 1,0,0,1,… with shift_num=4 → exactly 4 shift_code pulses, only in ready cycles.
  - With PRN_SEQ_STALL_CNT_EN defined: offset 6 = count of ready-low cycles.
- shift_num=0 → no shift_code; SAVE writes the loaded values unchanged; done at T14.
- abort at T5 → prn2_state_en never pulses; no ram_wr; no done; busy=0 at T6.
- A following start is accepted normally.
- start pulsed again while busy → ignored; single done.

Source files
------------

// File: rtl/prn_seq_pkg.sv
// Shared types and constants for the PRN context sequencer.
// PRN_SEQ_STALL_CNT_EN adds a stall counter saved as a fifth context word.
package prn_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_SETTLE,
        S_SHIFT,
        S_SAVE,
        S_DONE
    } seq_state_t;

    // DWORD offsets of the channel context from ctx_base
    localparam logic [2:0] CTX_CFG1   = 3'd0;
    localparam logic [2:0] CTX_CFG2   = 3'd1;
    localparam logic [2:0] CTX_STATE  = 3'd2;
    localparam logic [2:0] CTX_COUNT  = 3'd3;
    localparam logic [2:0] CTX_STATE2 = 3'd4;
    localparam logic [2:0] CTX_EPOCH  = 3'd5;
    localparam logic [2:0] CTX_STALL  = 3'd6;

    localparam int unsigned CTX_READ_LEN  = 6;
    localparam int unsigned SETTLE_CYCLES = 2;
    localparam int unsigned SETTLE_W      = $clog2(SETTLE_CYCLES);

`ifdef PRN_SEQ_STALL_CNT_EN
    localparam int unsigned SAVE_LEN = 5;
`else
    localparam int unsigned SAVE_LEN = 4;
`endif

endpackage

// File: rtl/prn_seq_ram_if.sv
// Channel state RAM access for the PRN sequencer: address generation for the
// READ and SAVE bursts and the read-return tag pipeline.
module prn_seq_ram_if
    import prn_seq_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_b,
    input  seq_state_t            state,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] base,
    output logic                  ram_rd,
    output logic                  ram_wr,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  rd_last,
    output logic                  wr_last,
    output logic [2:0]            wr_off,
    output logic                  tag_valid,
    output logic [2:0]            tag_off
);

    logic [2:0] cnt;

    // Strobes and address follow the FSM state and the burst index
    always_comb begin
        ram_rd   = (state == S_READ);
        ram_wr   = (state == S_SAVE);
        rd_last  = ram_rd && (cnt == 3'(CTX_READ_LEN - 1));
        wr_last  = ram_wr && (cnt == 3'(SAVE_LEN - 1));
        wr_off   = CTX_STATE + cnt;
        ram_addr = '0;
        if (ram_rd) begin
            ram_addr = base + ADDR_WIDTH'(cnt);
        end else if (ram_wr) begin
            ram_addr = base + ADDR_WIDTH'(wr_off);
        end
    end

    // Burst index: counts within a READ or SAVE burst, zero elsewhere
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt <= '0;
        end else if (!abort && ((ram_rd && !rd_last) || (ram_wr && !wr_last))) begin
            cnt <= cnt + 3'd1;
        end else begin
            cnt <= '0;
        end
    end

    // Tag each read so its data is recognised one cycle later; abort kills in-flight tags
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            tag_valid <= 1'b0;
            tag_off   <= '0;
        end else begin
            tag_valid <= ram_rd && !abort;
            tag_off   <= cnt;
        end
    end

endmodule

// File: rtl/prn_context_seq.sv
// Per-channel PRN context sequencer: loads a channel context into the PRN
// generator, issues the commanded code shifts and writes the context back.
// PRN_SEQ_STALL_CNT_EN enables the saved stall counter (context offset 6).
module prn_context_seq
    import prn_seq_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned SHIFT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_b,
    input  logic                   start,
    input  logic                   abort,
    input  logic [ADDR_WIDTH-1:0]  ctx_base,
    input  logic [SHIFT_WIDTH-1:0] shift_num,
    output logic                   busy,
    output logic                   done,
    output logic                   ram_rd,
    output logic                   ram_wr,
    output logic [ADDR_WIDTH-1:0]  ram_addr,
    output logic [31:0]            ram_wdata,
    input  logic [31:0]            ram_rdata,
    output logic [31:0]            prn_config,
    output logic [31:0]            prn2_config,
    output logic                   prn_state_en,
    output logic                   prn_count_en,
    output logic                   prn2_state_en,
    output logic [31:0]            prn_state_i,
    output logic [31:0]            prn_count_i,
    output logic [31:0]            prn2_state_i,
    input  logic [31:0]            prn_state_o,
    input  logic [31:0]            prn_count_o,
    input  logic [31:0]            prn2_state_o,
    output logic                   enable_2nd_prn,
    output logic                   shift_code,
    input  logic                   prn_reset,
    input  logic                   code_ready
);

    seq_state_t             state, state_nxt;
    logic [ADDR_WIDTH-1:0]  base_q;
    logic [SHIFT_WIDTH-1:0] remaining;
    logic [15:0]            epoch_cnt;
    logic [SETTLE_W-1:0]    settle_cnt;
    logic                   rd_last, wr_last, tag_valid;
    logic [2:0]             wr_off, tag_off;
`ifdef PRN_SEQ_STALL_CNT_EN
    logic [15:0]            stall_cnt;
`endif

    prn_seq_ram_if #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram_if (
        .clk       (clk),
        .rst_b     (rst_b),
        .state     (state),
        .abort     (abort),
        .base      (base_q),
        .ram_rd    (ram_rd),
        .ram_wr    (ram_wr),
        .ram_addr  (ram_addr),
        .rd_last   (rd_last),
        .wr_last   (wr_last),
        .wr_off    (wr_off),
        .tag_valid (tag_valid),
        .tag_off   (tag_off)
    );

    assign prn_state_i  = ram_rdata;
    assign prn_count_i  = ram_rdata;
    assign prn2_state_i = ram_rdata;

    // State register
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next state and per-state strobes; SHIFT leaves on the last shift so SAVE follows at once
    always_comb begin
        state_nxt     = state;
        busy          = (state != S_IDLE);
        done          = (state == S_DONE);
        shift_code    = (state == S_SHIFT) && code_ready && (remaining != '0);
        prn_state_en  = tag_valid && (tag_off == CTX_STATE);
        prn_count_en  = tag_valid && (tag_off == CTX_COUNT);
        prn2_state_en = tag_valid && (tag_off == CTX_STATE2);
        unique case (state)
            S_IDLE:   if (start) state_nxt = S_READ;
            S_READ:   if (abort) state_nxt = S_IDLE;
                      else if (rd_last) state_nxt = S_SETTLE;
            S_SETTLE: if (abort) state_nxt = S_IDLE;
                      else if (settle_cnt == SETTLE_W'(SETTLE_CYCLES - 1)) state_nxt = S_SHIFT;
            S_SHIFT:  if (abort) state_nxt = S_IDLE;
                      else if ((remaining == '0) ||
                               (shift_code && (remaining == SHIFT_WIDTH'(1)))) state_nxt = S_SAVE;
            S_SAVE:   if (abort) state_nxt = S_IDLE;
                      else if (wr_last) state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Writeback data: generator readbacks, then rebuilt epoch word
    always_comb begin
        ram_wdata = '0;
        if (ram_wr) begin
            case (wr_off)
                CTX_STATE:  ram_wdata = prn_state_o;
                CTX_COUNT:  ram_wdata = prn_count_o;
                CTX_STATE2: ram_wdata = prn2_state_o;
                CTX_EPOCH:  ram_wdata = {enable_2nd_prn, 15'h0, epoch_cnt};
`ifdef PRN_SEQ_STALL_CNT_EN
                CTX_STALL:  ram_wdata = {16'h0, stall_cnt};
`endif
                default:    ram_wdata = '0;
            endcase
        end
    end

    // Command capture, shift countdown and settle timer
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            base_q     <= '0;
            remaining  <= '0;
            settle_cnt <= '0;
        end else begin
            if (state == S_IDLE && start) begin
                base_q    <= ctx_base;
                remaining <= shift_num;
            end else if (shift_code) begin
                remaining <= remaining - SHIFT_WIDTH'(1);
            end
            settle_cnt <= (state == S_SETTLE) ? settle_cnt + SETTLE_W'(1) : '0;
        end
    end

    // Context fields captured from tagged read returns; epoch counts code roll-overs
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            prn_config     <= '0;
            prn2_config    <= '0;
            enable_2nd_prn <= 1'b0;
            epoch_cnt      <= '0;
        end else begin
            if (tag_valid && tag_off == CTX_CFG1) prn_config  <= ram_rdata;
            if (tag_valid && tag_off == CTX_CFG2) prn2_config <= ram_rdata;
            if (tag_valid && tag_off == CTX_EPOCH) begin
                enable_2nd_prn <= ram_rdata[31];
                epoch_cnt      <= ram_rdata[15:0];
            end else if (shift_code && prn_reset) begin
                epoch_cnt <= epoch_cnt + 16'd1;
            end
        end
    end

`ifdef PRN_SEQ_STALL_CNT_EN
    // Saturating count of SHIFT cycles lost to generator not ready
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            stall_cnt <= '0;
        end else if (state == S_IDLE && start) begin
            stall_cnt <= '0;
        end else if (state == S_SHIFT && remaining != '0 && !code_ready && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule
